// File: rtl/core_result_hub.sv
// Result collection hub: sequences per-child reset release, captures one result
// pair per child per round (sticky), and serves registered reads by child index.
module core_result_hub #(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 3,
    parameter int RST_DELAY    = 5,
    parameter int RST_STAGGER  = 0
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_CHILDREN-1:0]        child_flag,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_val_1,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_val_2,
    input  logic                           clear,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic [NUM_CHILDREN-1:0]        child_reset,
    output logic [DATA_W-1:0]              rd_val_1,
    output logic [DATA_W-1:0]              rd_val_2,
    output logic                           rd_valid,
    output logic [NUM_CHILDREN-1:0]        done_mask,
    output logic                           all_done,
    output logic [ADDR_W:0]                done_count
);

    localparam int MAX_CNT = RST_DELAY + (NUM_CHILDREN - 1) * RST_STAGGER;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNT);
    localparam logic [ADDR_W:0]  NC    = (ADDR_W + 1)'(NUM_CHILDREN);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CHILDREN-1:0] crst_q, crst_d;
    logic [NUM_CHILDREN-1:0] done_q, done_d;
    logic [NUM_CHILDREN-1:0] cap;
    logic [DATA_W-1:0]       v1_q [NUM_CHILDREN];
    logic [DATA_W-1:0]       v2_q [NUM_CHILDREN];
    logic [DATA_W-1:0]       v1_d [NUM_CHILDREN];
    logic [DATA_W-1:0]       v2_d [NUM_CHILDREN];
    logic [DATA_W-1:0]       rd1_q, rd1_d, rd2_q, rd2_d;
    logic                    rdv_q, rdv_d;
    logic [ADDR_W:0]         pop;

    always_comb begin
        cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
        // Release is judged on the post-edge count so child i drops on the edge it is reached.
        for (int i = 0; i < NUM_CHILDREN; i++)
            crst_d[i] = (cnt_d < CNT_W'(RST_DELAY + i * RST_STAGGER));

        cap    = child_flag & ~done_q & ~crst_q & {NUM_CHILDREN{~clear}};
        done_d = clear ? '0 : (done_q | cap);
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            v1_d[i] = cap[i] ? child_val_1[i*DATA_W +: DATA_W] : v1_q[i];
            v2_d[i] = cap[i] ? child_val_2[i*DATA_W +: DATA_W] : v2_q[i];
        end

        rd1_d = '0;
        rd2_d = '0;
        rdv_d = 1'b0;
        if ({1'b0, rd_addr} < NC) begin
            rd1_d = v1_d[rd_addr];
            rd2_d = v2_d[rd_addr];
            rdv_d = done_d[rd_addr];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            crst_q <= '1;
            done_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            rdv_q  <= 1'b0;
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                v1_q[i] <= '0;
                v2_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            crst_q <= crst_d;
            done_q <= done_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            rdv_q  <= rdv_d;
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                v1_q[i] <= v1_d[i];
                v2_q[i] <= v2_d[i];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CHILDREN; i++)
            pop = pop + {{ADDR_W{1'b0}}, done_q[i]};
    end

    assign child_reset = crst_q;
    assign rd_val_1    = rd1_q;
    assign rd_val_2    = rd2_q;
    assign rd_valid    = rdv_q;
    assign done_mask   = done_q;
    assign all_done    = &done_q;
    assign done_count  = pop;

endmodule

// File: doc/core_result_hub.md
CORE_RESULT_HUB -- requirements
Module: core_result_hub

Interface
REQ-001 SHALL provide the following parameters, one per line as name, default, meaning:
- NUM_CHILDREN, 5, number of child cores served, legal range 1..16.
- DATA_W, 32, width of each result word.
- ADDR_W, 3, read-address width; 2^ADDR_W >= NUM_CHILDREN is required.
- RST_DELAY, 5, cycles from Reset release to release of child 0; at least 1.
- RST_STAGGER, 0, extra release cycles between successive children.

REQ-002 SHALL provide the following ports, one per line as name, direction, width, meaning:
- Clk, in, 1, sole clock; all state updates on its rising edge.
- Reset, in, 1, synchronous, active-high.
- child_flag, in, NUM_CHILDREN, per-child result-ready level.
- child_val_1, in, NUM_CHILDREN*DATA_W, first result word; child i at [i*DATA_W +: DATA_W].
- child_val_2, in, NUM_CHILDREN*DATA_W, second result word; same packing.
- clear, in, 1, re-arm the collection round.
- rd_addr, in, ADDR_W, selects the child to read.
- child_reset, out, NUM_CHILDREN, per-child sequenced reset, active-high, registered.
- rd_val_1, out, DATA_W, registered stored word 1 of child rd_addr.
- rd_val_2, out, DATA_W, registered stored word 2 of child rd_addr.
- rd_valid, out, 1, registered; the read word belongs to a captured child.
- done_mask, out, NUM_CHILDREN, registered sticky capture bits.
- all_done, out, 1, AND of done_mask, combinational from registers.
- done_count, out, ADDR_W+1, population count of done_mask, combinational from registers.

Function
REQ-003 SHALL keep a release counter:
- cleared while Reset=1;
- incremented on each edge with Reset=0;
- saturating at RST_DELAY+(NUM_CHILDREN-1)*RST_STAGGER.

REQ-004 SHALL deassert child_reset[i] on the edge where the counter reaches RST_DELAY+i*RST_STAGGER, and hold it low until Reset is reasserted.

REQ-005 SHALL, when Reset is reasserted mid-sequence, drive all child_reset bits to 1 on that edge and restart the sequence from zero.

REQ-006 SHALL capture child i on an edge only when child_flag[i]=1, done_mask[i]=0, child_reset[i]=0, clear=0, and Reset=0.
- On capture, store child_val_1 and child_val_2 of child i.
- On the same edge, set done_mask[i].

REQ-007 SHALL ignore child_flag[i] and value changes for child i while done_mask[i]=1; the stored words are not overwritten.

REQ-008 SHALL capture any number of children on the same edge independently.

REQ-009 SHALL, on an edge with clear=1:
- zero done_mask;
- retain the stored words;
- suppress all captures on that edge, so clear wins over a simultaneous flag.
A flag still held high is captured on the next edge.

REQ-010 SHALL derive all_done=&done_mask and done_count=popcount(done_mask), with no added latency after done_mask.

REQ-011 SHALL, on every edge with rd_addr<NUM_CHILDREN:
- load rd_val_1 and rd_val_2 with the stored words of child rd_addr;
- load rd_valid with done_mask[rd_addr] as it stands after that edge's update.
Read latency is one cycle.

REQ-012 SHALL, on an edge with rd_addr>=NUM_CHILDREN, load rd_val_1=0, rd_val_2=0 and rd_valid=0.

REQ-013 SHALL use no combinational path from child_flag or child_val inputs to any output.

Reset
REQ-014 SHALL, on an edge with Reset=1, set:
- child_reset to all ones;
- release counter, done_mask, stored words, rd_val_1, rd_val_2 and rd_valid to 0.
As a result all_done=0 and done_count=0.

REQ-015 SHALL give Reset priority over clear, capture and read.

Verification
REQ-016 Default parameters; Reset high 3 cycles, then low -> child_reset=11111 through the 4th low edge, 00000 after the 5th.

REQ-017 RST_STAGGER=2 -> child_reset[0] falls after edge 5, [1] after edge 7, [4] after edge 13.
- Reset reasserted at edge 8 -> child_reset=11111 after edge 8.
- The sequence then restarts.

REQ-018 flag[2]=1 with val_1=0x000000AB, val_2=0x00001234 -> done_mask=00100 and done_count=1.
- rd_addr=2 -> next edge rd_val_1=0xAB, rd_val_2=0x1234, rd_valid=1.
- Later change of val_1 to 0xFF with flag still high -> stored word stays 0xAB.

REQ-019 All five flags high on one edge -> done_mask=11111, all_done=1, done_count=5 after that edge.
- Then clear=1 together with flag[0]=1 -> done_mask=00000 after that edge.
- flag[0] held high -> done_mask=00001 one edge later.

REQ-020 flag[3]=1 while child_reset[3]=1 -> no capture (done_mask[3]=0).
- rd_addr=6 -> rd_val_1=0, rd_val_2=0, rd_valid=0 next edge.

REQ-021 Reset asserted with done_mask=10110 -> all outputs return to the REQ-014 values after that edge.
